conv3_seq_ctrl: RTL

CONV3_SEQ_CTRL -- requirements
Module: conv3_seq_ctrl

---
 rtl/conv3_ctrl_pkg.sv | 23 ++
 rtl/conv3_addr_gen.sv | 82 ++++++++
 rtl/conv3_seq_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/conv3_ctrl_pkg.sv
// Shared types and sizing for the 3-tap convolution sequencer.
package conv3_ctrl_pkg;

  localparam int ACC_W       = 28;
  localparam int ADDR_W      = 16;
  localparam int BEAT_W      = 10;
  localparam int TAPS_PER_CH = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUT     = 3'd5
  } state_e;

  // 255 channels * 3 taps = 765 still fits the 10-bit beat counter.
  function automatic logic [BEAT_W-1:0] beats_for(input logic [7:0] n);
    return BEAT_W'(n) * BEAT_W'(TAPS_PER_CH);
  endfunction

endpackage

// File: rtl/conv3_addr_gen.sv
// Beat/phase counters and activation/weight read-address generation.
module conv3_addr_gen
  import conv3_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst,
  input  logic              init,
  input  logic              load,
  input  logic              step,
  input  logic [7:0]        num_ch_i,
  input  logic [ADDR_W-1:0] act_base_i,
  input  logic [ADDR_W-1:0] wgt_base_i,
  output logic [1:0]        phase_o,
  output logic              last_o,
  output logic              zero_o,
  output logic [ADDR_W-1:0] act_addr_o,
  output logic [ADDR_W-1:0] wgt_addr_o
);

  logic [BEAT_W-1:0] n_beats_q, n_beats_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [1:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] act_base_q, act_base_d;
  logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;

  always_comb begin
    n_beats_d  = n_beats_q;
    beat_d     = beat_q;
    phase_d    = phase_q;
    act_base_d = act_base_q;
    wgt_base_d = wgt_base_q;
    act_addr_d = act_addr_q;
    wgt_addr_d = wgt_addr_q;
    if (init) begin
      n_beats_d  = beats_for(num_ch_i);
      act_base_d = act_base_i;
      wgt_base_d = wgt_base_i;
      beat_d     = '0;
      phase_d    = '0;
    end
    if (load) begin
      act_addr_d = act_base_q;
      wgt_addr_d = wgt_base_q;
    end
    // Addresses track base+beat by incrementing; 16-bit wrap is natural.
    if (step) begin
      beat_d     = beat_q + 1'b1;
      phase_d    = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
      act_addr_d = act_addr_q + 1'b1;
      wgt_addr_d = wgt_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      n_beats_q  <= '0;
      beat_q     <= '0;
      phase_q    <= '0;
      act_base_q <= '0;
      wgt_base_q <= '0;
      act_addr_q <= '0;
      wgt_addr_q <= '0;
    end else begin
      n_beats_q  <= n_beats_d;
      beat_q     <= beat_d;
      phase_q    <= phase_d;
      act_base_q <= act_base_d;
      wgt_base_q <= wgt_base_d;
      act_addr_q <= act_addr_d;
      wgt_addr_q <= wgt_addr_d;
    end
  end

  assign phase_o    = phase_q;
  assign last_o     = (beat_q == n_beats_q - 1'b1);
  assign zero_o     = (n_beats_q == '0);
  assign act_addr_o = act_addr_q;
  assign wgt_addr_o = wgt_addr_q;

endmodule

// File: rtl/conv3_seq_ctrl.sv
// Job sequencer for a 3-tap-per-channel convolution datapath: issues beats,
// aligns accumulate strobes to the 1-cycle memory latency, hands off result.
module conv3_seq_ctrl
  import conv3_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              num_ch,
  input  logic [ADDR_W-1:0]       act_base,
  input  logic [ADDR_W-1:0]       wgt_base,
  output logic [ADDR_W-1:0]       act_addr,
  output logic [ADDR_W-1:0]       wgt_addr,
  output logic                    acc_clr,
  output logic                    acc_we,
  output logic [1:0]              sel,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] res_o,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy
);

  state_e state_q, state_d;

  logic       ag_init, ag_load, ag_step;
  logic [1:0] phase;
  logic       last_beat, zero_job;

  logic                    acc_we_q, acc_we_d;
  logic [1:0]              sel_q, sel_d;
  logic signed [ACC_W-1:0] res_q, res_d;

  conv3_addr_gen u_addr_gen (
    .clk_i      (clk_i),
    .rst        (rst),
    .init       (ag_init),
    .load       (ag_load),
    .step       (ag_step),
    .num_ch_i   (num_ch),
    .act_base_i (act_base),
    .wgt_base_i (wgt_base),
    .phase_o    (phase),
    .last_o     (last_beat),
    .zero_o     (zero_job),
    .act_addr_o (act_addr),
    .wgt_addr_o (wgt_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   state_d = zero_job ? S_CAPTURE : S_RUN;
      S_RUN:     if (last_beat) state_d = S_DRAIN;
      S_DRAIN:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUT;
      S_OUT:     if (res_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    acc_clr   = (state_q == S_CLEAR);
    res_valid = (state_q == S_OUT);
    ag_init   = (state_q == S_IDLE) && start;
    ag_load   = (state_q == S_CLEAR) && !zero_job;
    ag_step   = (state_q == S_RUN) && !last_beat;
  end

  // Strobe and tap select lag the issued beat by the memory read latency.
  always_comb begin
    acc_we_d = (state_q == S_RUN);
    sel_d    = (state_q == S_RUN) ? phase : 2'd0;
    res_d    = (state_q == S_CAPTURE) ? acc_i : res_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      acc_we_q <= 1'b0;
      sel_q    <= 2'd0;
      res_q    <= '0;
    end else begin
      acc_we_q <= acc_we_d;
      sel_q    <= sel_d;
      res_q    <= res_d;
    end
  end

  assign acc_we = acc_we_q;
  assign sel    = sel_q;
  assign res_o  = res_q;

endmodule
